// File: rtl/wb_clear_arbiter.sv
// -----------------------------------------------------------------------------
// wb_clear_arbiter
//
// Shares the register-file write port and the scoreboard clear port among
// several long-latency writeback sources (remote-load response, divider, FPU).
// Requesters are arbitrated round-robin. The winner is registered into a
// one-entry output stage, which drives the RF write. The scoreboard clear for
// that register is issued in the same cycle the write retires.
//
// Parameters
//   num_req_p          number of writeback requesters (>= 2)
//   data_width_p       writeback data width
//   id_width_p         register id width
//   x0_tied_to_zero_p  when 1, writes to id 0 are consumed and discarded
//
// Ports
//   clk_i       clock
//   reset_n_i   asynchronous, active-low reset
//   v_i         per-requester writeback pending
//   id_i        per-requester destination register
//   data_i      per-requester writeback data
//   yumi_o      per-requester consume strobe (one-hot or zero)
//   rf_ready_i  RF write port free this cycle (main pipeline has priority)
//   rf_wen_o    output stage holds a valid write
//   rf_waddr_o  write address
//   rf_wdata_o  write data
//   clear_o     scoreboard clear, high in the cycle the write retires
//   clear_id_o  register being cleared (same as rf_waddr_o)
// -----------------------------------------------------------------------------
module wb_clear_arbiter #(
  parameter int num_req_p         = 3,
  parameter int data_width_p      = 32,
  parameter int id_width_p        = 5,
  parameter bit x0_tied_to_zero_p = 1'b0
) (
  input  logic                                    clk_i,
  input  logic                                    reset_n_i,

  input  logic [num_req_p-1:0]                    v_i,
  input  logic [num_req_p-1:0][id_width_p-1:0]    id_i,
  input  logic [num_req_p-1:0][data_width_p-1:0]  data_i,
  output logic [num_req_p-1:0]                    yumi_o,

  input  logic                                    rf_ready_i,
  output logic                                    rf_wen_o,
  output logic [id_width_p-1:0]                   rf_waddr_o,
  output logic [data_width_p-1:0]                 rf_wdata_o,

  output logic                                    clear_o,
  output logic [id_width_p-1:0]                   clear_id_o
);

  localparam int ptr_w_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  typedef logic [ptr_w_lp-1:0] ptr_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                    out_v_r;
  logic [id_width_p-1:0]   out_id_r;
  logic [data_width_p-1:0] out_data_r;
  ptr_t                    rr_ptr_r;

  // ---------------------------------------------------------------------------
  // Round-robin grant: first valid requester at or after rr_ptr_r, wrapping.
  // The grant depends only on v_i and the pointer; the accept enable gates it
  // afterwards, so yumi_o never sees v_i except through the grant.
  // ---------------------------------------------------------------------------
  logic [num_req_p-1:0] grant;
  ptr_t                 grant_idx;
  logic                 grant_found;

  // NOTE: every signal written in this block gets a default first, so no
  // path through the loop can leave it unassigned and infer a latch.
  always_comb begin
    int idx;
    grant       = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int k = 0; k < num_req_p; k++) begin
      idx = int'(rr_ptr_r) + k;
      if (idx >= num_req_p) idx = idx - num_req_p;
      if (!grant_found && v_i[idx]) begin
        grant_found = 1'b1;
        grant_idx   = ptr_t'(idx);
      end
    end
    if (grant_found) grant[grant_idx] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Accept / retire control
  // ---------------------------------------------------------------------------
  // The stage can take a new entry when empty, or when its current entry is
  // retiring this cycle (refill in the same cycle it drains).
  logic accept;
  logic retire;
  logic take;
  logic drop;
  logic load;
  ptr_t ptr_next;

  assign accept = ~out_v_r | rf_ready_i;
  assign retire = out_v_r & rf_ready_i;
  assign yumi_o = grant & {num_req_p{accept}};
  assign take   = grant_found & accept;

  // Writes to x0 are consumed but never reach the RF or the scoreboard.
  assign drop   = x0_tied_to_zero_p && (id_i[grant_idx] == '0);
  assign load   = take & ~drop;

  assign ptr_next = (grant_idx == ptr_t'(num_req_p - 1)) ? '0 : grant_idx + 1'b1;

  // ---------------------------------------------------------------------------
  // Control registers (valid bit and arbitration pointer)
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      out_v_r  <= 1'b0;
      rr_ptr_r <= '0;
    end else begin
      if (take) begin
        rr_ptr_r <= ptr_next;
        // A dropped x0 write leaves the stage as it would be with no take:
        // it empties only if the current entry retires.
        out_v_r  <= drop ? (out_v_r & ~rf_ready_i) : 1'b1;
      end else if (retire) begin
        out_v_r  <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output-stage payload
  // ---------------------------------------------------------------------------
  // NOTE: the payload has no reset. It is qualified by out_v_r, which is
  // reset, so its power-up contents are never observed as a write.
  always_ff @(posedge clk_i) begin
    if (load) begin
      out_id_r   <= id_i[grant_idx];
      out_data_r <= data_i[grant_idx];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Address and data come straight from registers, so they hold steady for
  // as long as rf_ready_i stalls the write.
  assign rf_wen_o   = out_v_r;
  assign rf_waddr_o = out_id_r;
  assign rf_wdata_o = out_data_r;

  // The clear fires exactly when the RF accepts the write.
  assign clear_o    = retire;
  assign clear_id_o = out_id_r;

  // ---------------------------------------------------------------------------
  // Protocol checks on the requester side
  // ---------------------------------------------------------------------------
`ifndef SYNTHESIS
  for (genvar a = 0; a < num_req_p; a++) begin : g_req_chk
    // A pending writeback must be held, unchanged, until it is consumed.
    assert property (@(posedge clk_i) disable iff (!reset_n_i)
      (v_i[a] && !yumi_o[a]) |=> (v_i[a] && $stable(id_i[a]) && $stable(data_i[a])));

    // Two in-flight writebacks to the same real register mean the
    // scoreboard has been bypassed upstream.
    for (genvar b = a + 1; b < num_req_p; b++) begin : g_pair_chk
      assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(v_i[a] && v_i[b] && (id_i[a] == id_i[b]) && (id_i[a] != '0)));
    end
  end
`endif

endmodule

// File: tb/tb_wb_clear_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_clear_arbiter
//
// Self-checking bench for wb_clear_arbiter (3 requesters, x0 discarded).
// Each requester is a queue of pending writebacks. A reference model of the
// arbiter predicts yumi_o every cycle; accepted writes are pushed onto a
// scoreboard queue and popped and compared when the DUT retires them.
// Directed checks cover single write, round-robin order, back-pressure, x0
// drop and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_wb_clear_arbiter;

  localparam int n_req  = 3;
  localparam int id_w   = 5;
  localparam int data_w = 32;

  typedef struct {
    logic [id_w-1:0]   id;
    logic [data_w-1:0] data;
  } ent_t;

  logic                          clk_i;
  logic                          reset_n_i;
  logic [n_req-1:0]              v_i;
  logic [n_req-1:0][id_w-1:0]    id_i;
  logic [n_req-1:0][data_w-1:0]  data_i;
  logic [n_req-1:0]              yumi_o;
  logic                          rf_ready_i;
  logic                          rf_wen_o;
  logic [id_w-1:0]               rf_waddr_o;
  logic [data_w-1:0]             rf_wdata_o;
  logic                          clear_o;
  logic [id_w-1:0]               clear_id_o;

  wb_clear_arbiter #(
    .num_req_p         (n_req),
    .data_width_p      (data_w),
    .id_width_p        (id_w),
    .x0_tied_to_zero_p (1'b1)
  ) dut (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .v_i        (v_i),
    .id_i       (id_i),
    .data_i     (data_i),
    .yumi_o     (yumi_o),
    .rf_ready_i (rf_ready_i),
    .rf_wen_o   (rf_wen_o),
    .rf_waddr_o (rf_waddr_o),
    .rf_wdata_o (rf_wdata_o),
    .clear_o    (clear_o),
    .clear_id_o (clear_id_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Requester stimulus queues, scoreboard and reference model state.
  ent_t req_q [n_req][$];
  ent_t sb_q[$];
  logic m_out_v;
  int   m_ptr;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic push_req(input int r, input logic [id_w-1:0] id, input logic [data_w-1:0] data);
    ent_t e;
    e.id   = id;
    e.data = data;
    req_q[r].push_back(e);
  endtask

  // Present the head of every requester queue to the DUT.
  task automatic apply_inputs();
    for (int r = 0; r < n_req; r++) begin
      if (req_q[r].size() > 0) begin
        v_i[r]    = 1'b1;
        id_i[r]   = req_q[r][0].id;
        data_i[r] = req_q[r][0].data;
      end else begin
        v_i[r]    = 1'b0;
        id_i[r]   = '0;
        data_i[r] = '0;
      end
    end
  endtask

  // One clock: entered and left just after a falling edge. Drives inputs,
  // compares the DUT against the model, advances the model, then clocks.
  task automatic cycle();
    logic [n_req-1:0] exp_yumi;
    int   g;
    logic retire;
    ent_t e;
    apply_inputs();
    #1;
    g = -1;
    for (int k = 0; k < n_req; k++) begin
      int r;
      r = (m_ptr + k) % n_req;
      if (g < 0 && req_q[r].size() > 0) g = r;
    end
    exp_yumi = '0;
    if (g >= 0 && (!m_out_v || rf_ready_i)) exp_yumi[g] = 1'b1;
    retire = m_out_v & rf_ready_i;

    check("yumi", 64'(yumi_o), 64'(exp_yumi));
    check("wen", 64'(rf_wen_o), 64'(m_out_v));
    check("clear", 64'(clear_o), 64'(retire));
    if (m_out_v && sb_q.size() > 0) begin
      check("waddr", 64'(rf_waddr_o), 64'(sb_q[0].id));
      check("wdata", 64'(rf_wdata_o), 64'(sb_q[0].data));
    end
    if (retire && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("clear_id", 64'(clear_id_o), 64'(e.id));
    end

    if (exp_yumi != '0) begin
      e = req_q[g].pop_front();
      m_ptr = (g + 1) % n_req;
      if (e.id == '0) begin
        m_out_v = m_out_v & ~rf_ready_i;
      end else begin
        sb_q.push_back(e);
        m_out_v = 1'b1;
      end
    end else if (retire) begin
      m_out_v = 1'b0;
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  function automatic bit busy();
    int pend;
    pend = 0;
    for (int r = 0; r < n_req; r++) pend += req_q[r].size();
    return (pend != 0) || m_out_v;
  endfunction

  // Run until all requesters and the output stage are empty, within a budget.
  task automatic drain(input string tag);
    rf_ready_i = 1'b1;
    for (int n = 0; n < 50 && busy(); n++) cycle();
    check(tag, 64'(busy()), 64'd0);
  endtask

  task automatic model_reset();
    for (int r = 0; r < n_req; r++) req_q[r].delete();
    sb_q.delete();
    m_out_v = 1'b0;
    m_ptr   = 0;
    apply_inputs();
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);
  endtask

  initial begin
    reset_n_i  = 1'b0;
    rf_ready_i = 1'b1;
    v_i        = '0;
    id_i       = '0;
    data_i     = '0;
    model_reset();
    do_reset();

    // ---- Reset state ------------------------------------------------------
    #1;
    check("rst_wen", 64'(rf_wen_o), 64'd0);
    check("rst_clear", 64'(clear_o), 64'd0);
    check("rst_yumi", 64'(yumi_o), 64'd0);
    @(negedge clk_i);

    // ---- Single write -----------------------------------------------------
    push_req(1, 5'd7, 32'hDEAD_BEEF);
    apply_inputs();
    #1;
    check("sw_yumi", 64'(yumi_o), 64'b010);
    cycle();
    apply_inputs();
    #1;
    check("sw_wen", 64'(rf_wen_o), 64'd1);
    check("sw_waddr", 64'(rf_waddr_o), 64'd7);
    check("sw_wdata", 64'(rf_wdata_o), 64'hDEAD_BEEF);
    check("sw_clear", 64'(clear_o), 64'd1);
    check("sw_clear_id", 64'(clear_id_o), 64'd7);
    cycle();
    #1;
    check("sw_idle_wen", 64'(rf_wen_o), 64'd0);
    check("sw_idle_clear", 64'(clear_o), 64'd0);
    @(negedge clk_i);

    // ---- Round-robin: all valid, ids 1,2,3 --------------------------------
    do_reset();
    for (int i = 0; i < 2; i++)
      for (int r = 0; r < n_req; r++)
        push_req(r, 5'(r + 1), 32'h1000 + 32'(i * 16 + r));
    for (int i = 0; i < 6; i++) begin
      apply_inputs();
      #1;
      check("rr_grant", 64'(yumi_o), 64'(1 << (i % n_req)));
      cycle();
    end
    drain("rr_drain");

    // ---- Back-pressure ----------------------------------------------------
    push_req(0, 5'd9, 32'hCAFE_0009);
    cycle();
    rf_ready_i = 1'b0;
    push_req(1, 5'd10, 32'hCAFE_000A);
    push_req(2, 5'd11, 32'hCAFE_000B);
    for (int i = 0; i < 4; i++) begin
      apply_inputs();
      #1;
      check("bp_yumi", 64'(yumi_o), 64'd0);
      check("bp_clear", 64'(clear_o), 64'd0);
      check("bp_wen", 64'(rf_wen_o), 64'd1);
      check("bp_waddr", 64'(rf_waddr_o), 64'd9);
      check("bp_wdata", 64'(rf_wdata_o), 64'hCAFE_0009);
      cycle();
    end
    rf_ready_i = 1'b1;
    apply_inputs();
    #1;
    check("bp_release_clear", 64'(clear_o), 64'd1);
    check("bp_release_id", 64'(clear_id_o), 64'd9);
    check("bp_release_yumi", 64'(yumi_o), 64'b010);
    cycle();
    drain("bp_drain");

    // ---- x0 drop on requester 2 -------------------------------------------
    push_req(2, 5'd0, 32'h0BAD_0000);
    apply_inputs();
    #1;
    check("x0_yumi", 64'(yumi_o), 64'b100);
    cycle();
    #1;
    check("x0_wen", 64'(rf_wen_o), 64'd0);
    check("x0_clear", 64'(clear_o), 64'd0);
    @(negedge clk_i);
    push_req(0, 5'd4, 32'h4444_4444);
    push_req(1, 5'd5, 32'h5555_5555);
    push_req(2, 5'd6, 32'h6666_6666);
    apply_inputs();
    #1;
    check("x0_ptr_wrap", 64'(yumi_o), 64'b001);
    drain("x0_drain");

    // ---- Random traffic through the scoreboard ----------------------------
    for (int i = 0; i < 60; i++) begin
      rf_ready_i = ($urandom_range(0, 3) != 0);
      for (int r = 0; r < n_req; r++)
        if (req_q[r].size() == 0 && $urandom_range(0, 1) == 1)
          // Ids are unique per requester (r*8 + 1..8), so no two pending
          // writebacks share a register.
          push_req(r, 5'(r * 8 + $urandom_range(1, 8)), $urandom);
      cycle();
    end
    drain("rand_drain");

    // ---- Asynchronous reset mid-operation ---------------------------------
    push_req(1, 5'd12, 32'h1212_1212);
    cycle();
    rf_ready_i = 1'b1;
    #2;
    reset_n_i = 1'b0;
    model_reset();
    #1;
    check("arst_wen", 64'(rf_wen_o), 64'd0);
    check("arst_clear", 64'(clear_o), 64'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);
    push_req(0, 5'd13, 32'h1313_1313);
    push_req(1, 5'd14, 32'h1414_1414);
    push_req(2, 5'd15, 32'h1515_1515);
    apply_inputs();
    #1;
    check("arst_first_grant", 64'(yumi_o), 64'b001);
    drain("arst_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "bench time limit reached");
  end

endmodule
